// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bit-fusion PE pipeline.
package bitfusion_pkg;

    typedef logic [1:0] prec_mode_t;

    localparam prec_mode_t MODE_FULL    = 2'd0;
    localparam prec_mode_t MODE_HALF    = 2'd1;
    localparam prec_mode_t MODE_QUARTER = 2'd2;

    // Number of independent lanes for a precision mode; reserved code runs as FULL.
    function automatic logic [2:0] lane_count(input prec_mode_t mode);
        case (mode)
            MODE_HALF:    return 3'd2;
            MODE_QUARTER: return 3'd4;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/bitfusion_brick_mul.sv
// Signed brick multiplier. Operands arrive already extended by one bit, so
// one signed multiply covers the signed and unsigned cases.
module bitfusion_brick_mul #(
    parameter int BW = 3
) (
    input  logic signed [BW-1:0]   i_a,
    input  logic signed [BW-1:0]   i_b,
    output logic signed [2*BW-1:0] o_p
);

    // Plain signed product of the extended quarter slices.
    assign o_p = i_a * i_b;

endmodule

// File: rtl/bitfusion_pe_pipe.sv
// Two-stage bit-fusion MAC PE with valid/ready flow control.
// S1: 4x4 grid of quarter-width bricks, composed into 1/2/4 lane products.
// S2: psum accumulate. Define BITFUSION_SATURATE_EN to clamp the sum and
// flag ovf; otherwise the sum wraps and ovf stays 0.
module bitfusion_pe_pipe
    import bitfusion_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_act,
    input  logic [DATA_W-1:0]        weight,
    input  logic                     s_in,
    input  logic                     s_weight,
    input  logic [1:0]               prec_mode,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PSUM_W-1:0] psum_out,
    output logic                     ovf
);

    localparam int Q  = DATA_W / 4;
    localparam int SW = 2 * DATA_W + 2;

    logic [3:0]              w_top;
    logic signed [Q:0]       w_a_ext [4];
    logic signed [Q:0]       w_b_ext [4];
    logic signed [2*Q+1:0]   w_prod  [4][4];
    logic signed [SW-1:0]    w_sump;
    logic signed [PSUM_W-1:0] w_res;
    logic                    w_ovf;
    logic                    w_s1_adv, w_s2_adv;

    logic                    r_s1_valid;
    logic signed [SW-1:0]    r_s1_sump;
    logic signed [PSUM_W-1:0] r_s1_psum;
    logic                    r_out_valid;
    logic signed [PSUM_W-1:0] r_psum_out;
    logic                    r_ovf;

    // Mark quarters holding a lane MSB; only those carry the operand sign.
    always_comb begin
        case (prec_mode_t'(prec_mode))
            MODE_HALF:    w_top = 4'b1010;
            MODE_QUARTER: w_top = 4'b1111;
            default:      w_top = 4'b1000;
        endcase
        for (int k = 0; k < 4; k++) begin
            w_a_ext[k] = {s_in     & w_top[k] & in_act[k*Q+Q-1], in_act[k*Q +: Q]};
            w_b_ext[k] = {s_weight & w_top[k] & weight[k*Q+Q-1], weight[k*Q +: Q]};
        end
    end

    // One multiplier array for all modes: every activation quarter times every weight quarter.
    for (genvar j = 0; j < 4; j++) begin : g_row
        for (genvar k = 0; k < 4; k++) begin : g_col
            bitfusion_brick_mul #(.BW(Q + 1)) u_brick (
                .i_a (w_a_ext[j]),
                .i_b (w_b_ext[k]),
                .o_p (w_prod[j][k])
            );
        end
    end

    // Sum bricks whose quarters share a lane, shifted by their position inside the lane.
    always_comb begin
        int g;
        g = 4 / int'(lane_count(prec_mode_t'(prec_mode)));
        w_sump = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                if ((j / g) == (k / g))
                    w_sump = w_sump + (SW'(w_prod[j][k]) <<< (((j % g) + (k % g)) * Q));
            end
        end
    end

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

`ifdef BITFUSION_SATURATE_EN
    logic signed [PSUM_W:0] w_sum;
    // One guard bit detects overflow; clamp toward the sign of the true sum.
    always_comb begin
        w_sum = (PSUM_W+1)'(r_s1_psum) + (PSUM_W+1)'(r_s1_sump);
        w_ovf = w_sum[PSUM_W] ^ w_sum[PSUM_W-1];
        if (w_ovf)
            w_res = w_sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        else
            w_res = w_sum[PSUM_W-1:0];
    end
`else
    // Wrapping accumulate; ovf never raised.
    always_comb begin
        w_res = r_s1_psum + PSUM_W'(r_s1_sump);
        w_ovf = 1'b0;
    end
`endif

    // S1: capture brick sum and psum on accept; hold while S2 is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sump  <= '0;
            r_s1_psum  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sump <= w_sump;
                r_s1_psum <= psum_in;
            end
        end
    end

    // S2: accumulate; output stays frozen while downstream is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_psum_out  <= '0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_psum_out <= w_res;
                r_ovf      <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign psum_out  = r_psum_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bitfusion_pe_pipe.sv
// Directed bench for bitfusion_pe_pipe (DATA_W=8, PSUM_W=20).
module tb_bitfusion_pe_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_act = '0;
    logic [7:0]  weight = '0;
    logic        s_in = 1'b0;
    logic        s_weight = 1'b0;
    logic [1:0]  prec_mode = '0;
    logic [19:0] psum_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] psum_out;
    logic        ovf;

    int n_chk = 0;
    int n_pass = 0;

    bitfusion_pe_pipe #(.DATA_W(8), .PSUM_W(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .weight    (weight),
        .s_in      (s_in),
        .s_weight  (s_weight),
        .prec_mode (prec_mode),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .psum_out  (psum_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        sa;
        logic        sw;
        logic [7:0]  act;
        logic [7:0]  wt;
        logic [19:0] psum;
        logic [19:0] exp;
        logic        eovf;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string n, logic [1:0] m, logic sa, logic sw, logic [7:0] a,
                                logic [7:0] w, logic [19:0] p, logic [19:0] e, logic eo);
        vec_t v;
        v.name = n; v.mode = m; v.sa = sa; v.sw = sw; v.act = a; v.wt = w;
        v.psum = p; v.exp = e; v.eovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input logic [1:0] m, input logic sa, input logic sw,
                         input logic [7:0] a, input logic [7:0] w, input logic [19:0] p);
        prec_mode = m; s_in = sa; s_weight = sw; in_act = a; weight = w; psum_in = p;
        in_valid = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk("full_ss",     2'd0, 1, 1, 8'hFF, 8'h02, 20'd10,   20'd8,     1'b0);
        vecs[1]  = mk("full_uu",     2'd0, 0, 0, 8'hFF, 8'hFF, 20'd0,    20'h0FE01, 1'b0);
        vecs[2]  = mk("full_su",     2'd0, 1, 0, 8'hFF, 8'hFF, 20'd0,    20'hFFF01, 1'b0);
        vecs[3]  = mk("half_ss",     2'd1, 1, 1, 8'h3F, 8'h22, 20'd0,    20'd4,     1'b0);
        vecs[4]  = mk("quarter_uu",  2'd2, 0, 0, 8'hFF, 8'hFF, 20'd100,  20'd136,   1'b0);
        vecs[5]  = mk("mode3_full",  2'd3, 0, 0, 8'hFF, 8'hFF, 20'd100,  20'd65125, 1'b0);
        vecs[6]  = mk("quarter_ss",  2'd2, 1, 1, 8'hFF, 8'hFF, 20'd0,    20'd4,     1'b0);
        vecs[7]  = mk("half_uu",     2'd1, 0, 0, 8'hFF, 8'hFF, 20'd0,    20'd450,   1'b0);
        vecs[8]  = mk("full_minmin", 2'd0, 1, 1, 8'h80, 8'h80, 20'd0,    20'h04000, 1'b0);
        vecs[9]  = mk("full_us",     2'd0, 0, 1, 8'h80, 8'hFF, 20'd0,    20'hFFF80, 1'b0);
        vecs[10] = mk("full_negps",  2'd0, 1, 1, 8'h7F, 8'h7F, 20'hFB1E0, 20'hFF0E1, 1'b0);
`ifdef BITFUSION_SATURATE_EN
        vecs[11] = mk("ovf_pos",     2'd0, 0, 0, 8'h01, 8'h01, 20'h7FFFF, 20'h7FFFF, 1'b1);
        vecs[12] = mk("ovf_neg",     2'd0, 1, 1, 8'hFF, 8'h01, 20'h80000, 20'h80000, 1'b1);
`else
        vecs[11] = mk("ovf_pos",     2'd0, 0, 0, 8'h01, 8'h01, 20'h7FFFF, 20'h80000, 1'b0);
        vecs[12] = mk("ovf_neg",     2'd0, 1, 1, 8'hFF, 8'h01, 20'h80000, 20'h7FFFF, 1'b0);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_psum_out", 32'(psum_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Table: one transaction at a time, exact 2-cycle latency
        for (int i = 0; i < 13; i++) begin
            int t;
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].sa, vecs[i].sw, vecs[i].act, vecs[i].wt, vecs[i].psum);
            t = 0;
            while (!in_ready && t < 10) begin @(negedge clk); t++; end
            chk({vecs[i].name, "_accept"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, "_lat1"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, "_psum"}, 32'(psum_out), 32'(vecs[i].exp));
            chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].eovf));
        end

        // Stall: two transactions held, third blocked, then drained in order
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'd0, 0, 0, 8'h01, 8'h01, 20'd1);      // A -> 2
        @(negedge clk);
        drive(2'd0, 0, 0, 8'h01, 8'h01, 20'd2);      // B -> 3
        chk("stall_accept_b", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(2'd0, 0, 0, 8'h01, 8'h01, 20'd3);      // C -> 4
        chk("stall_full_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_psum_a", 32'(psum_out), 32'd2);
        @(negedge clk);
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        chk("stall_hold_psum", 32'(psum_out), 32'd2);
        out_ready = 1'b1;
        #1;
        chk("release_ready_comb", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_b_valid", 32'(out_valid), 32'd1);
        chk("drain_b_psum", 32'(psum_out), 32'd3);
        @(negedge clk);
        chk("drain_c_valid", 32'(out_valid), 32'd1);
        chk("drain_c_psum", 32'(psum_out), 32'd4);
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset while both stages are full
        out_ready = 1'b0;
        drive(2'd0, 0, 0, 8'h01, 8'h01, 20'd5);
        repeat (3) @(negedge clk);
        chk("prerst_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_psum", 32'(psum_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
